// File: rtl/rv32_pkg.sv
// Shared RV32 constants: immediate format codes, opcodes and the
// immediate scatter helper used by the encoder.
package rv32_pkg;

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6f;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } enc_t;

  function automatic logic [31:0] scatter(
    input logic [2:0]  sel,
    input logic [31:0] imm,
    input logic [31:0] base
  );
    logic [31:0] w;
    w = base;
    unique case (1'b1)
      (sel == FMT_I): w[31:20] = imm[11:0];
      (sel == FMT_S): begin
        w[31:25] = imm[11:5];
        w[11:7]  = imm[4:0];
      end
      (sel == FMT_B): begin
        w[31]    = imm[12];
        w[30:25] = imm[10:5];
        w[11:8]  = imm[4:1];
        w[7]     = imm[11];
      end
      (sel == FMT_U): w[31:12] = imm[31:12];
      (sel == FMT_J): begin
        w[31]    = imm[20];
        w[30:21] = imm[10:1];
        w[20]    = imm[11];
        w[19:12] = imm[19:12];
      end
      default: w = base;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imm_enc_check.sv
// Range/alignment checker: flags immediates that the selected
// format cannot represent, and any unknown format code.
module imm_enc_check
  import rv32_pkg::*;
(
  input  logic [2:0]  i_sel,
  input  logic [31:0] i_imm,
  output logic        o_err
);

  logic sx11;
  logic sx12;
  logic sx20;

  assign sx11 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign sx12 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
  assign sx20 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

  always_comb begin
    o_err = 1'b1;
    unique case (1'b1)
      (i_sel == FMT_I): o_err = ~sx11;
      (i_sel == FMT_S): o_err = ~sx11;
      (i_sel == FMT_B): o_err = ~sx12 | i_imm[0];
      (i_sel == FMT_U): o_err = |i_imm[11:0];
      (i_sel == FMT_J): o_err = ~sx20 | i_imm[0];
      default:          o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_enc.sv
// Two-stage immediate encoder with running word address.
// Define IMM_ENC_CHECK_EN to build in the range checker.
module imm_enc
  import rv32_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_sel,
  input  logic [31:0]       i_imm,
  input  logic [31:0]       i_base,
  input  logic              i_clr,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_instruction,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_err
);

  logic              chk_err;
  logic              s1_valid;
  logic              s2_valid;
  enc_t              s1_q;
  enc_t              s2_q;
  logic [ADDR_W-1:0] s2_addr;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              accept;
  logic              xfer;
  logic              s2_load;

`ifdef IMM_ENC_CHECK_EN
  imm_enc_check u_chk (
    .i_sel (i_sel),
    .i_imm (i_imm),
    .o_err (chk_err)
  );
`else
  assign chk_err = 1'b0;
`endif

  assign xfer    = s2_valid & i_ready;
  assign s2_load = ~s2_valid | i_ready;
  assign o_ready = ~s1_valid | s2_load;
  assign accept  = i_valid & o_ready;

  // Word loaded into S2 takes the post-edge count so that
  // back-to-back transfers get consecutive addresses.
  always_comb begin
    cnt_nxt = cnt_q;
    if (i_clr)
      cnt_nxt = '0;
    else if (xfer)
      cnt_nxt = cnt_q + ADDR_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_q.inst <= scatter(i_sel, i_imm, i_base);
      s1_q.err  <= chk_err;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
      s2_addr  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_q    <= s1_q;
        s2_addr <= cnt_nxt;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_nxt;
  end

  assign o_valid       = s2_valid;
  assign o_instruction = s2_q.inst;
  assign o_addr        = s2_addr;
  assign o_err         = s2_valid & s2_q.err;

endmodule

// File: tb/tb_imm_enc.sv
// Directed bench for imm_enc: formats, errors, backpressure,
// address wrap, clear and mid-stream reset.
module tb_imm_enc;
  import rv32_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_clr = 1'b0;
  logic        i_ready = 1'b1;
  logic [2:0]  i_sel = 3'd0;
  logic [31:0] i_imm = '0;
  logic [31:0] i_base = '0;

  logic        o_ready, o_valid, o_err;
  logic [31:0] o_instruction;
  logic [9:0]  o_addr;

  logic        w_ready, w_valid, w_err;
  logic [31:0] w_inst;
  logic [1:0]  w_addr;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_inst[$];
  logic [9:0]  q_addr[$];
  logic        q_err[$];
  logic [1:0]  qw_addr[$];
  logic [31:0] qw_inst[$];
  logic        qw_err[$];

`ifdef IMM_ENC_CHECK_EN
  localparam logic EXP_CHK = 1'b1;
`else
  localparam logic EXP_CHK = 1'b0;
`endif

  imm_enc u_dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_sel         (i_sel),
    .i_imm         (i_imm),
    .i_base        (i_base),
    .i_clr         (i_clr),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_instruction (o_instruction),
    .o_addr        (o_addr),
    .o_err         (o_err)
  );

  imm_enc #(.ADDR_W(2)) u_w (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_valid       (i_valid),
    .o_ready       (w_ready),
    .i_sel         (i_sel),
    .i_imm         (i_imm),
    .i_base        (i_base),
    .i_clr         (i_clr),
    .o_valid       (w_valid),
    .i_ready       (i_ready),
    .o_instruction (w_inst),
    .o_addr        (w_addr),
    .o_err         (w_err)
  );

  always #5 i_clk = ~i_clk;

  // Inputs change only at posedge+1, so a negedge sample
  // predicts the transfer at the next rising edge.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      q_inst.push_back(o_instruction);
      q_addr.push_back(o_addr);
      q_err.push_back(o_err);
    end
    if (i_rst_n && w_valid && i_ready) begin
      qw_addr.push_back(w_addr);
      qw_inst.push_back(w_inst);
      qw_err.push_back(w_err);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr_q();
    q_inst.delete();
    q_addr.delete();
    q_err.delete();
    qw_addr.delete();
    qw_inst.delete();
    qw_err.delete();
  endtask

  task automatic clear_cnt();
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
  endtask

  task automatic send(
    input logic [2:0]  s,
    input logic [31:0] m,
    input logic [31:0] b
  );
    int n;
    n = 0;
    i_valid = 1'b1;
    i_sel   = s;
    i_imm   = m;
    i_base  = b;
    @(negedge i_clk);
    while (!o_ready && n < 50) begin
      tick();
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: o_ready=%0b want 1", o_ready);
    end
    tick();
  endtask

  task automatic drain();
    i_valid = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid: got %0b want 0", o_valid);
    end
    checks++;
    if (o_instruction !== 32'h0) begin
      errors++; $display("FAIL rst_inst: got %h want 0", o_instruction);
    end
    checks++;
    if (o_addr !== 10'd0 || o_err !== 1'b0) begin
      errors++; $display("FAIL rst_addr_err: got %0d/%0b want 0/0", o_addr, o_err);
    end
    repeat (2) tick();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1 || w_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready: got %0b/%0b want 1/1", o_ready, w_ready);
    end
  endtask

  task automatic test_i_format();
    tick();
    clr_q();
    send(FMT_I, 32'hffff_ffff, {25'd0, OP_IMM});
    i_valid = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL i_lat1: o_valid got %0b want 0", o_valid);
    end
    tick();
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b1) begin
      errors++; $display("FAIL i_lat2: o_valid got %0b want 1", o_valid);
    end
    checks++;
    if (o_instruction !== 32'hfff0_0013) begin
      errors++; $display("FAIL i_inst: got %h want fff00013", o_instruction);
    end
    checks++;
    if (o_err !== 1'b0 || o_addr !== 10'd0) begin
      errors++; $display("FAIL i_err_addr: got %0b/%0d want 0/0", o_err, o_addr);
    end
    tick();
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL i_done: o_valid got %0b want 0", o_valid);
    end
    tick();
  endtask

  task automatic test_s_b();
    logic [31:0] ei[2];
    ei = '{32'h0000_2423, 32'hfe00_0ee3};
    clear_cnt();
    clr_q();
    send(FMT_S, 32'd8, {17'd0, 3'b010, 5'd0, OP_STORE});
    send(FMT_B, 32'hffff_fffc, {25'd0, OP_BRANCH});
    drain();
    checks++;
    if (q_inst.size() != 2) begin
      errors++; $display("FAIL sb_count: got %0d want 2", q_inst.size());
    end
    for (int k = 0; k < 2; k++) begin
      if (k < q_inst.size()) begin
        checks++;
        if (q_inst[k] !== ei[k] || q_err[k] !== 1'b0 || q_addr[k] !== 10'(k)) begin
          errors++;
          $display("FAIL sb_word%0d: got %h/%0b/%0d want %h/0/%0d",
                   k, q_inst[k], q_err[k], q_addr[k], ei[k], k);
        end
      end
    end
  endtask

  task automatic test_u_j();
    logic [31:0] ei[3];
    ei = '{32'h1234_5037, 32'h0010_006f, 32'h7ff0_0013};
    clear_cnt();
    clr_q();
    send(FMT_U, 32'h1234_5000, {25'd0, OP_LUI});
    send(FMT_J, 32'h0000_0800, {25'd0, OP_JAL});
    send(FMT_I, 32'h0000_07ff, {25'd0, OP_IMM});
    drain();
    checks++;
    if (q_inst.size() != 3) begin
      errors++; $display("FAIL uj_count: got %0d want 3", q_inst.size());
    end
    for (int k = 0; k < 3; k++) begin
      if (k < q_inst.size()) begin
        checks++;
        if (q_inst[k] !== ei[k] || q_err[k] !== 1'b0 || q_addr[k] !== 10'(k)) begin
          errors++;
          $display("FAIL uj_word%0d: got %h/%0b/%0d want %h/0/%0d",
                   k, q_inst[k], q_err[k], q_addr[k], ei[k], k);
        end
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] ei[3];
    ei = '{32'h0000_0163, 32'h8000_0013, 32'h1234_5678};
    clear_cnt();
    clr_q();
    send(FMT_B, 32'd3, {25'd0, OP_BRANCH});
    send(FMT_I, 32'h0000_0800, {25'd0, OP_IMM});
    send(3'd6, 32'hdead_beef, 32'h1234_5678);
    drain();
    checks++;
    if (q_inst.size() != 3) begin
      errors++; $display("FAIL err_count: got %0d want 3", q_inst.size());
    end
    for (int k = 0; k < 3; k++) begin
      if (k < q_inst.size()) begin
        checks++;
        if (q_inst[k] !== ei[k] || q_err[k] !== EXP_CHK) begin
          errors++;
          $display("FAIL err_word%0d: got %h/%0b want %h/%0b",
                   k, q_inst[k], q_err[k], ei[k], EXP_CHK);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_cnt();
    clr_q();
    i_ready = 1'b0;
    send(FMT_I, 32'd1, {25'd0, OP_IMM});
    send(FMT_I, 32'd2, {25'd0, OP_IMM});
    i_valid = 1'b1;
    i_imm   = 32'd3;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      checks++;
      if (o_ready !== 1'b0 || o_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hs%0d: rdy/vld got %0b/%0b want 0/1", c, o_ready, o_valid);
      end
      checks++;
      if (o_instruction !== 32'h0010_0013 || o_addr !== 10'd0) begin
        errors++;
        $display("FAIL bp_hold%0d: got %h/%0d want 00100013/0", c, o_instruction, o_addr);
      end
      tick();
    end
    i_ready = 1'b1;
    send(FMT_I, 32'd3, {25'd0, OP_IMM});
    send(FMT_I, 32'd4, {25'd0, OP_IMM});
    send(FMT_I, 32'd5, {25'd0, OP_IMM});
    drain();
    checks++;
    if (q_inst.size() != 5) begin
      errors++; $display("FAIL bp_count: got %0d want 5", q_inst.size());
    end
    for (int k = 0; k < 5; k++) begin
      if (k < q_inst.size()) begin
        checks++;
        if (q_inst[k] !== {12'(k + 1), 20'h00013} || q_addr[k] !== 10'(k)) begin
          errors++;
          $display("FAIL bp_word%0d: got %h/%0d want %h/%0d",
                   k, q_inst[k], q_addr[k], {12'(k + 1), 20'h00013}, k);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] ea[5];
    ea = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    clear_cnt();
    clr_q();
    for (int k = 0; k < 5; k++)
      send(FMT_U, {20'(k + 1), 12'd0}, {25'd0, OP_LUI});
    drain();
    checks++;
    if (qw_addr.size() != 5) begin
      errors++; $display("FAIL wrap_count: got %0d want 5", qw_addr.size());
    end
    for (int k = 0; k < 5; k++) begin
      if (k < qw_addr.size()) begin
        checks++;
        if (qw_addr[k] !== ea[k] || qw_inst[k] !== {20'(k + 1), 12'h037} || qw_err[k] !== 1'b0) begin
          errors++;
          $display("FAIL wrap_word%0d: got %0d/%h want %0d/%h",
                   k, qw_addr[k], qw_inst[k], ea[k], {20'(k + 1), 12'h037});
        end
      end
    end
  endtask

  task automatic test_clr_xfer();
    logic [9:0] ea[3];
    ea = '{10'd0, 10'd0, 10'd1};
    clear_cnt();
    clr_q();
    send(FMT_I, 32'd1, {25'd0, OP_IMM});
    send(FMT_I, 32'd2, {25'd0, OP_IMM});
    i_clr = 1'b1;
    send(FMT_I, 32'd3, {25'd0, OP_IMM});
    i_clr = 1'b0;
    drain();
    checks++;
    if (q_addr.size() != 3) begin
      errors++; $display("FAIL clr_count: got %0d want 3", q_addr.size());
    end
    for (int k = 0; k < 3; k++) begin
      if (k < q_addr.size()) begin
        checks++;
        if (q_addr[k] !== ea[k]) begin
          errors++; $display("FAIL clr_addr%0d: got %0d want %0d", k, q_addr[k], ea[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_cnt();
    clr_q();
    send(FMT_I, 32'd1, {25'd0, OP_IMM});
    send(FMT_I, 32'd2, {25'd0, OP_IMM});
    send(FMT_I, 32'd3, {25'd0, OP_IMM});
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_instruction !== 32'h0 || o_addr !== 10'd0) begin
      errors++;
      $display("FAIL rstmid_out: got %0b/%h/%0d want 0/0/0", o_valid, o_instruction, o_addr);
    end
    repeat (2) tick();
    i_rst_n = 1'b1;
    clr_q();
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_hs: got %0b/%0b want 1/0", o_ready, o_valid);
    end
    tick();
    send(FMT_S, 32'd8, {17'd0, 3'b010, 5'd0, OP_STORE});
    drain();
    checks++;
    if (q_addr.size() != 1) begin
      errors++; $display("FAIL rstmid_count: got %0d want 1", q_addr.size());
    end else begin
      checks++;
      if (q_addr[0] !== 10'd0 || q_inst[0] !== 32'h0000_2423) begin
        errors++;
        $display("FAIL rstmid_word: got %0d/%h want 0/00002423", q_addr[0], q_inst[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_i_format();
    test_s_b();
    test_u_j();
    test_errors();
    test_backpressure();
    test_wrap();
    test_clr_xfer();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
